// File: rtl/prbs_monitor_pkg.sv
// Shared types and helpers for the multi-lane PRBS BER monitor.
package prbs_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLDOFF  = 2'd1,
    COUNTING = 2'd2
  } lane_state_t;

  // Increment a counter of the given width, holding at all-ones instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/prbs_lane_counter.sv
// One lane of the BER monitor: lock-qualification FSM plus saturating error,
// counted-cycle and lock-loss counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | window closed, counters frozen and readable
//   HOLDOFF  | window open, waiting for LOCK_HOLDOFF consecutive locked cycles
//   COUNTING | lane qualified, every locked cycle counted
module prbs_lane_counter
  import prbs_monitor_pkg::*;
#(
  parameter int ERR_WIDTH    = 32,
  parameter int CYCLE_WIDTH  = 48,
  parameter int LOCK_HOLDOFF = 16,
  parameter int LOSS_WIDTH   = 16
) (
  input  logic                   i_sysclk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_close,
  input  logic                   i_locked,
  input  logic                   i_err,
  output logic [ERR_WIDTH-1:0]   o_err_count,
  output logic [CYCLE_WIDTH-1:0] o_locked_cycles,
  output logic [LOSS_WIDTH-1:0]  o_lock_losses
);

  localparam int HO_W = (LOCK_HOLDOFF > 1) ? $clog2(LOCK_HOLDOFF) : 1;
  localparam logic [HO_W-1:0] HOLD_LAST = HO_W'(LOCK_HOLDOFF - 1);

  lane_state_t            r_state, w_state_nxt;
  logic [HO_W-1:0]        r_hold, w_hold_nxt;
  logic [ERR_WIDTH-1:0]   r_err, w_err_nxt;
  logic [CYCLE_WIDTH-1:0] r_lock, w_lock_nxt;
  logic [LOSS_WIDTH-1:0]  r_loss, w_loss_nxt;

  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_err   <= '0;
      r_lock  <= '0;
      r_loss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
      r_lock  <= w_lock_nxt;
      r_loss  <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_err_nxt   = r_err;
    w_lock_nxt  = r_lock;
    w_loss_nxt  = r_loss;
    case (r_state)
      HOLDOFF: begin
        if (!i_locked) begin
          w_hold_nxt = '0;
        end else if (r_hold == HOLD_LAST) begin
          w_state_nxt = COUNTING;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + HO_W'(1);
        end
      end
      COUNTING: begin
        if (!i_locked) begin
          w_state_nxt = HOLDOFF;
          w_hold_nxt  = '0;
          w_loss_nxt  = LOSS_WIDTH'(sat_inc(64'(r_loss), LOSS_WIDTH));
        end else begin
          w_lock_nxt = CYCLE_WIDTH'(sat_inc(64'(r_lock), CYCLE_WIDTH));
          if (i_err) w_err_nxt = ERR_WIDTH'(sat_inc(64'(r_err), ERR_WIDTH));
        end
      end
      default: ;
    endcase
    // The closing cycle is still counted above; only the state is forced idle.
    if (i_close) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
    end
    if (i_start) begin
      w_state_nxt = HOLDOFF;
      w_hold_nxt  = '0;
      w_err_nxt   = '0;
      w_lock_nxt  = '0;
      w_loss_nxt  = '0;
    end
  end

  assign o_err_count     = r_err;
  assign o_locked_cycles = r_lock;
  assign o_lock_losses   = r_loss;

endmodule

// File: rtl/prbs_ber_monitor.sv
// Multi-lane PRBS BER monitor: measurement window control, per-lane counters
// and a registered readback mux.
module prbs_ber_monitor
  import prbs_monitor_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int ERR_WIDTH    = 32,
  parameter int CYCLE_WIDTH  = 48,
  parameter int LOCK_HOLDOFF = 16,
  parameter int LOSS_WIDTH   = 16,
  localparam int RD_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CYCLE_WIDTH-1:0] window_len,
  input  logic [NUM_LANES-1:0]   lane_locked,
  input  logic [NUM_LANES-1:0]   lane_err,
  input  logic [RD_W-1:0]        rd_lane,
  output logic [ERR_WIDTH-1:0]   rd_err_count,
  output logic [CYCLE_WIDTH-1:0] rd_locked_cycles,
  output logic [LOSS_WIDTH-1:0]  rd_lock_losses,
  output logic                   running,
  output logic                   done,
  output logic [CYCLE_WIDTH-1:0] elapsed
);

  logic                   r_running;
  logic                   r_done;
  logic [CYCLE_WIDTH-1:0] r_elapsed;
  logic [CYCLE_WIDTH-1:0] r_window_len;
  logic [ERR_WIDTH-1:0]   r_rd_err;
  logic [CYCLE_WIDTH-1:0] r_rd_lock;
  logic [LOSS_WIDTH-1:0]  r_rd_loss;
  logic                   w_close;

  logic [ERR_WIDTH-1:0]   w_err  [NUM_LANES];
  logic [CYCLE_WIDTH-1:0] w_lock [NUM_LANES];
  logic [LOSS_WIDTH-1:0]  w_loss [NUM_LANES];

  // Last open cycle of the window; a simultaneous start restarts instead.
  assign w_close = r_running && !start &&
                   (stop || ((r_window_len != '0) &&
                             (r_elapsed == r_window_len - CYCLE_WIDTH'(1))));

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_elapsed    <= '0;
      r_window_len <= '0;
    end else begin
      r_done <= w_close;
      if (start) begin
        r_running    <= 1'b1;
        r_elapsed    <= '0;
        r_window_len <= window_len;
      end else if (r_running) begin
        r_elapsed <= CYCLE_WIDTH'(sat_inc(64'(r_elapsed), CYCLE_WIDTH));
        if (w_close) r_running <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    prbs_lane_counter #(
      .ERR_WIDTH   (ERR_WIDTH),
      .CYCLE_WIDTH (CYCLE_WIDTH),
      .LOCK_HOLDOFF(LOCK_HOLDOFF),
      .LOSS_WIDTH  (LOSS_WIDTH)
    ) u_lane (
      .i_sysclk       (sysclk),
      .i_rst          (rst),
      .i_start        (start),
      .i_close        (w_close),
      .i_locked       (lane_locked[g]),
      .i_err          (lane_err[g]),
      .o_err_count    (w_err[g]),
      .o_locked_cycles(w_lock[g]),
      .o_lock_losses  (w_loss[g])
    );
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_rd_err  <= '0;
      r_rd_lock <= '0;
      r_rd_loss <= '0;
    end else if (int'(rd_lane) < NUM_LANES) begin
      r_rd_err  <= w_err[rd_lane];
      r_rd_lock <= w_lock[rd_lane];
      r_rd_loss <= w_loss[rd_lane];
    end else begin
      r_rd_err  <= '0;
      r_rd_lock <= '0;
      r_rd_loss <= '0;
    end
  end

  assign rd_err_count     = r_rd_err;
  assign rd_locked_cycles = r_rd_lock;
  assign rd_lock_losses   = r_rd_loss;
  assign running          = r_running;
  assign done             = r_done;
  assign elapsed          = r_elapsed;

endmodule

// File: tb/tb_prbs_ber_monitor.sv
// Directed bench for prbs_ber_monitor: a full-width 4-lane instance and a
// 3-lane instance with a 4-bit error counter sharing the same stimulus.
module tb_prbs_ber_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [47:0] window_len;
  logic [3:0]  lane_locked;
  logic [3:0]  lane_err;
  logic [1:0]  rd_lane;

  logic [31:0] err1;
  logic [47:0] lck1;
  logic [15:0] los1;
  logic        running1, done1;
  logic [47:0] elapsed1;

  logic [3:0]  err2;
  logic [47:0] lck2;
  logic [15:0] los2;
  logic        running2, done2;
  logic [47:0] elapsed2;

  int n_checks = 0;
  int n_fail   = 0;

  prbs_ber_monitor #(
    .NUM_LANES(4), .ERR_WIDTH(32), .CYCLE_WIDTH(48), .LOCK_HOLDOFF(16), .LOSS_WIDTH(16)
  ) u_dut (
    .sysclk(clk), .rst(rst), .start(start), .stop(stop), .window_len(window_len),
    .lane_locked(lane_locked), .lane_err(lane_err), .rd_lane(rd_lane),
    .rd_err_count(err1), .rd_locked_cycles(lck1), .rd_lock_losses(los1),
    .running(running1), .done(done1), .elapsed(elapsed1)
  );

  prbs_ber_monitor #(
    .NUM_LANES(3), .ERR_WIDTH(4), .CYCLE_WIDTH(48), .LOCK_HOLDOFF(16), .LOSS_WIDTH(16)
  ) u_dut_small (
    .sysclk(clk), .rst(rst), .start(start), .stop(stop), .window_len(window_len),
    .lane_locked(lane_locked[2:0]), .lane_err(lane_err[2:0]), .rd_lane(rd_lane),
    .rd_err_count(err2), .rd_locked_cycles(lck2), .rd_lock_losses(los2),
    .running(running2), .done(done2), .elapsed(elapsed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      lane;
    longint unsigned err1, lck1, los1;
    longint unsigned err2, lck2, los2;
  } rb_t;

  rb_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2'd0, 99,  984, 0, 15, 984, 0};
    tbl[1] = '{2'd1, 0,   965, 1, 0,  965, 1};
    tbl[2] = '{2'd2, 984, 984, 0, 15, 984, 0};
    tbl[3] = '{2'd3, 0,   984, 0, 0,  0,   0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; window_len = '0;
    lane_locked = '0; lane_err = '0; rd_lane = '0;
    tick();
    check("reset running", 64'(running1), 64'd0);
    check("reset done", 64'(done1), 64'd0);
    check("reset elapsed", 64'(elapsed1), 64'd0);
    check("reset rd_err", 64'(err1), 64'd0);
    check("reset rd_locked", 64'(lck1), 64'd0);
    check("reset rd_losses", 64'(los1), 64'd0);
    rst = 1'b0;
    tick();

    // Window of 1000 cycles; lane 0 errors every 10th cycle, lane 1 drops
    // lock for three cycles, lane 2 errors continuously.
    lane_locked = 4'hF;
    window_len  = 48'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("w1000 running after start", 64'(running1), 64'd1);
    check("w1000 elapsed after start", 64'(elapsed1), 64'd0);
    for (int k = 1; k <= 1000; k++) begin
      lane_err    = {1'b0, 1'b1, 1'b0, (k % 10 == 0)};
      lane_locked = {1'b1, 1'b1, !(k >= 500 && k <= 502), 1'b1};
      if (k == 600) rd_lane = 2'd2;
      if (k == 700) check("sat err mid-window", 64'(err2), 64'd15);
      if (k == 1000) begin
        check("last open cycle elapsed", 64'(elapsed1), 64'd999);
        check("last open cycle running", 64'(running1), 64'd1);
        check("last open cycle no done", 64'(done1), 64'd0);
      end
      tick();
    end
    lane_err = '0;
    lane_locked = 4'hF;
    check("w1000 done", 64'(done1), 64'd1);
    check("w1000 running low", 64'(running1), 64'd0);
    check("w1000 elapsed", 64'(elapsed1), 64'd1000);
    check("small done", 64'(done2), 64'd1);
    check("small running low", 64'(running2), 64'd0);
    check("small elapsed", 64'(elapsed2), 64'd1000);
    tick();
    check("done one cycle", 64'(done1), 64'd0);
    check("elapsed frozen", 64'(elapsed1), 64'd1000);

    for (int i = 0; i < 4; i++) begin
      rd_lane = tbl[i].lane;
      tick();
      tick();
      check($sformatf("lane%0d err", i), 64'(err1), tbl[i].err1);
      check($sformatf("lane%0d locked", i), 64'(lck1), tbl[i].lck1);
      check($sformatf("lane%0d losses", i), 64'(los1), tbl[i].los1);
      check($sformatf("small lane%0d err", i), 64'(err2), tbl[i].err2);
      check($sformatf("small lane%0d locked", i), 64'(lck2), tbl[i].lck2);
      check($sformatf("small lane%0d losses", i), 64'(los2), tbl[i].los2);
    end

    // Shortest window: W=1.
    window_len = 48'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("w1 running", 64'(running1), 64'd1);
    check("w1 no early done", 64'(done1), 64'd0);
    tick();
    check("w1 done", 64'(done1), 64'd1);
    check("w1 running low", 64'(running1), 64'd0);
    check("w1 elapsed", 64'(elapsed1), 64'd1);

    // Unlimited window closed by stop.
    window_len = 48'd0;
    rd_lane = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 500; k++) begin
      if (k == 500) begin
        check("w0 elapsed before stop", 64'(elapsed1), 64'd499);
        stop = 1'b1;
      end
      tick();
      stop = 1'b0;
    end
    check("stop done", 64'(done1), 64'd1);
    check("stop running low", 64'(running1), 64'd0);
    check("stop elapsed", 64'(elapsed1), 64'd500);
    tick();
    check("stop lane2 err cleared", 64'(err1), 64'd0);
    check("stop lane2 locked", 64'(lck1), 64'd484);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle stop no done", 64'(done1), 64'd0);
    tick();
    check("idle stop no done later", 64'(done1), 64'd0);
    check("idle stop running", 64'(running1), 64'd0);

    // Restart with start and stop together while running.
    lane_err = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("pre-restart running", 64'(running1), 64'd1);
    check("pre-restart lane2 err", 64'(err1), 64'd33);
    check("pre-restart small err", 64'(err2), 64'd15);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("restart running", 64'(running1), 64'd1);
    check("restart elapsed", 64'(elapsed1), 64'd0);
    check("restart no done", 64'(done1), 64'd0);
    tick();
    check("restart no done later", 64'(done1), 64'd0);
    check("restart err cleared", 64'(err1), 64'd0);
    check("restart locked cleared", 64'(lck1), 64'd0);

    // Asynchronous reset in the middle of a window.
    for (int i = 0; i < 20; i++) tick();
    check("pre-reset locked", 64'(lck1), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async rst running", 64'(running1), 64'd0);
    check("async rst elapsed", 64'(elapsed1), 64'd0);
    check("async rst done", 64'(done1), 64'd0);
    check("async rst rd_err", 64'(err1), 64'd0);
    check("async rst rd_locked", 64'(lck1), 64'd0);
    tick();
    rst = 1'b0;
    lane_err = '0;
    tick();
    tick();
    check("post-rst no done", 64'(done1), 64'd0);
    check("post-rst running", 64'(running1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
